// File: rtl/rx_frame.sv
// Purpose : Ethernet RX deframer: preamble/SFD hunt, dst-MAC + ethertype filter, payload into ping-pong bank, FCS check.
// Latency : each payload byte is written 1 cycle after it is sampled; the decision pulse comes 1 cycle after the first rxdv=0 sample.
// Backpressure: none; the line cannot be stalled, so every byte is consumed in the cycle it arrives.
//
// Ports:
//   clk125, rst               clock and synchronous active-high reset
//   rxd[7:0], rxdv, rxer      byte stream from the IDDR capture stage
//   wr_en, wr_addr, wr_data   payload write port {bank, offset} into the consumer's dual-port RAM
//   rd_bank                   last committed bank (the only bank the consumer may read)
//   frame_ok, frame_bad       1-cycle decision pulses
//   seq, good_cnt, bad_cnt    sequence number of the last good frame and wrapping frame counters
module rx_frame #(
    parameter logic [47:0] MAC     = 48'h0088_dab8_bf08,
    parameter logic [15:0] ETYPE   = 16'h1919,
    parameter int          PAY_LEN = 1024,
    localparam int         AW      = $clog2(PAY_LEN)
) (
    input  logic          clk125,
    input  logic          rst,
    input  logic [7:0]    rxd,
    input  logic          rxdv,
    input  logic          rxer,
    output logic          wr_en,
    output logic [AW:0]   wr_addr,
    output logic [7:0]    wr_data,
    output logic          rd_bank,
    output logic          frame_ok,
    output logic          frame_bad,
    output logic [15:0]   seq,
    output logic [15:0]   good_cnt,
    output logic [15:0]   bad_cnt
);

    localparam int          IW       = $clog2(PAY_LEN + 20);
    localparam logic [IW-1:0] IDX_SEQ0 = IW'(14);
    localparam logic [IW-1:0] IDX_SEQ1 = IW'(15);
    localparam logic [IW-1:0] IDX_PAY0 = IW'(16);
    localparam logic [IW-1:0] IDX_PAYN = IW'(PAY_LEN + 15);
    localparam logic [IW-1:0] IDX_LAST = IW'(PAY_LEN + 19);
    localparam logic [31:0]   RESIDUE  = 32'hDEBB_20E3;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_PAY, S_FCS, S_DONE, S_DROP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [31:0]     crc_q, crc_d;
    logic            err_q, err_d;
    logic            long_q, long_d;
    logic [15:0]     seq_tmp_q, seq_tmp_d;
    logic            bank_q, bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [15:0]     seq_q, seq_d;
    logic [15:0]     good_cnt_q, good_cnt_d;
    logic [15:0]     bad_cnt_q, bad_cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW:0]     wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_bad_q, frame_bad_d;

    logic            decide;
    logic            good_evt;
    logic            bad_evt;
    logic            hdr_chk;
    logic [7:0]      hdr_exp;
    logic [31:0]     crc_upd;

    // Byte-serial reflected CRC-32 (poly EDB88320), no final inversion:
    // running it across the received FCS leaves the fixed residue.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_upd = crc_byte(crc_q, rxd);

    // Header bytes that must match, indexed by position after SFD.
    always_comb begin
        hdr_chk = 1'b1;
        hdr_exp = 8'h00;
        case (idx_q)
            IW'(0):  hdr_exp = MAC[7:0];
            IW'(1):  hdr_exp = MAC[15:8];
            IW'(2):  hdr_exp = MAC[23:16];
            IW'(3):  hdr_exp = MAC[31:24];
            IW'(4):  hdr_exp = MAC[39:32];
            IW'(5):  hdr_exp = MAC[47:40];
            IW'(12): hdr_exp = ETYPE[15:8];
            IW'(13): hdr_exp = ETYPE[7:0];
            default: hdr_chk = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        crc_d       = crc_q;
        err_d       = err_q;
        long_d      = long_q;
        seq_tmp_d   = seq_tmp_q;
        bank_d      = bank_q;
        rd_bank_d   = rd_bank_q;
        seq_d       = seq_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_ok_d  = 1'b0;
        frame_bad_d = 1'b0;
        decide      = 1'b0;
        good_evt    = 1'b0;
        bad_evt     = 1'b0;

        case (state_q)
            S_IDLE: begin
                long_d = 1'b0;
                if (rxdv) state_d = (rxd == 8'h55) ? S_PRE : S_DROP;
            end
            S_PRE: begin
                if (!rxdv) begin
                    state_d = S_IDLE;
                end else if (rxd == 8'hD5) begin
                    // Entry into PRE already required one 55 byte.
                    state_d = S_HDR;
                    idx_d   = '0;
                    crc_d   = 32'hFFFF_FFFF;
                    err_d   = 1'b0;
                end else if (rxd != 8'h55) begin
                    state_d = S_DROP;
                end
            end
            S_HDR, S_PAY, S_FCS: begin
                if (!rxdv) begin
                    decide = 1'b1;
                end else begin
                    crc_d = crc_upd;
                    idx_d = idx_q + IW'(1);
                    if (rxer) err_d = 1'b1;
                    case (state_q)
                        S_HDR: begin
                            if (hdr_chk && (rxd != hdr_exp)) state_d = S_DROP;
                            if (idx_q == IDX_SEQ0) seq_tmp_d[7:0] = rxd;
                            if (idx_q == IDX_SEQ1) begin
                                seq_tmp_d[15:8] = rxd;
                                state_d         = S_PAY;
                            end
                        end
                        S_PAY: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {bank_q, AW'(idx_q - IDX_PAY0)};
                            wr_data_d = rxd;
                            if (idx_q == IDX_PAYN) state_d = S_FCS;
                        end
                        default: begin
                            if (idx_q == IDX_LAST) state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_DONE: begin
                if (rxdv) begin
                    // Overlong frame: remember it so the bad pulse lands on the rxdv fall.
                    state_d = S_DROP;
                    long_d  = 1'b1;
                end else begin
                    decide = 1'b1;
                end
            end
            default: begin // S_DROP
                if (!rxdv) begin
                    state_d = S_IDLE;
                    long_d  = 1'b0;
                    bad_evt = long_q;
                end
            end
        endcase

        if (decide) begin
            state_d = S_IDLE;
            if ((state_q == S_DONE) && (crc_q == RESIDUE) && !err_q) begin
                good_evt = 1'b1;
            end else if ((state_q != S_HDR) || (idx_q >= IDX_SEQ0)) begin
                // A runt that ends before the ethertype is confirmed stays silent.
                bad_evt = 1'b1;
            end
        end

        if (good_evt) begin
            frame_ok_d = 1'b1;
            seq_d      = seq_tmp_q;
            rd_bank_d  = bank_q;
            bank_d     = ~bank_q;
            good_cnt_d = good_cnt_q + 16'd1;
        end
        if (bad_evt) begin
            frame_bad_d = 1'b1;
            bad_cnt_d   = bad_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk125) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            crc_q       <= '0;
            err_q       <= 1'b0;
            long_q      <= 1'b0;
            seq_tmp_q   <= '0;
            bank_q      <= 1'b0;
            rd_bank_q   <= 1'b0;
            seq_q       <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_bad_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            long_q      <= long_d;
            seq_tmp_q   <= seq_tmp_d;
            bank_q      <= bank_d;
            rd_bank_q   <= rd_bank_d;
            seq_q       <= seq_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_bad_q <= frame_bad_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_bank   = rd_bank_q;
    assign frame_ok  = frame_ok_q;
    assign frame_bad = frame_bad_q;
    assign seq       = seq_q;
    assign good_cnt  = good_cnt_q;
    assign bad_cnt   = bad_cnt_q;

endmodule

// File: tb/tb_rx_frame.sv
// Purpose : frame-level model of rx_frame: each sent frame is classified from its bytes and
//           turned into per-cycle expected writes and decision pulses, compared on every negedge.
// Ports   : none (top-level bench).
module tb_rx_frame;

    logic        clk125 = 1'b0;
    logic        rst    = 1'b1;
    logic [7:0]  rxd    = 8'h00;
    logic        rxdv   = 1'b0;
    logic        rxer   = 1'b0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_bank;
    logic        frame_ok;
    logic        frame_bad;
    logic [15:0] seq;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    rx_frame dut (
        .clk125(clk125), .rst(rst), .rxd(rxd), .rxdv(rxdv), .rxer(rxer),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank),
        .frame_ok(frame_ok), .frame_bad(frame_bad), .seq(seq),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #4 clk125 = ~clk125;

    int   cyc   = 0;
    logic rst_s = 1'b1;
    always @(posedge clk125) begin
        cyc++;
        rst_s = rst;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_wr   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expectations keyed by the posedge number after which the output must be visible.
    int          exp_wr_off[int];
    byte unsigned exp_wr_dat[int];
    int          exp_ok_seq[int];
    bit          exp_bad[int];

    logic        m_bank, m_rd_bank;
    logic [15:0] m_seq, m_good, m_bad;

    always @(negedge clk125) begin
        int n;
        n = cyc;
        if (rst_s) begin
            chk("reset_outputs",
                {wr_en, wr_addr, wr_data, rd_bank, frame_ok, frame_bad, seq, good_cnt, bad_cnt}, '0);
            m_bank = 0; m_rd_bank = 0; m_seq = 0; m_good = 0; m_bad = 0;
            exp_wr_off.delete(); exp_wr_dat.delete(); exp_ok_seq.delete(); exp_bad.delete();
        end else begin
            if (wr_en) n_wr++;
            chk("wr_en", wr_en, exp_wr_off.exists(n) ? 1 : 0);
            if (wr_en && exp_wr_off.exists(n)) begin
                chk("wr_addr", wr_addr, {m_bank, 10'(exp_wr_off[n])});
                chk("wr_data", wr_data, exp_wr_dat[n]);
            end
            if (exp_wr_off.exists(n)) begin
                exp_wr_off.delete(n);
                exp_wr_dat.delete(n);
            end
            chk("frame_ok", frame_ok, exp_ok_seq.exists(n) ? 1 : 0);
            if (exp_ok_seq.exists(n)) begin
                m_seq     = 16'(exp_ok_seq[n]);
                m_rd_bank = m_bank;
                m_bank    = ~m_bank;
                m_good    = m_good + 16'd1;
                exp_ok_seq.delete(n);
            end
            chk("frame_bad", frame_bad, exp_bad.exists(n) ? 1 : 0);
            if (exp_bad.exists(n)) begin
                m_bad = m_bad + 16'd1;
                exp_bad.delete(n);
            end
            chk("status", {rd_bank, seq, good_cnt, bad_cnt}, {m_rd_bank, m_seq, m_good, m_bad});
        end
    end

    // Standard Ethernet CRC-32 (with final inversion) over the first n bytes of q.
    function automatic logic [31:0] crc32(input byte unsigned q[$], input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    byte unsigned mac_b[6] = '{8'h08, 8'hbf, 8'hb8, 8'hda, 8'h88, 8'h00};
    byte unsigned frm[$];

    task automatic build(input logic [15:0] sq, input logic [7:0] d0, input logic [15:0] et, input int salt);
        logic [31:0] c;
        frm.delete();
        for (int k = 0; k < 6; k++) frm.push_back(k == 0 ? d0 : mac_b[k]);
        for (int k = 0; k < 6; k++) frm.push_back(8'(8'h20 + k));
        frm.push_back(et[15:8]); frm.push_back(et[7:0]);
        frm.push_back(sq[7:0]);  frm.push_back(sq[15:8]);
        for (int i = 0; i < 1024; i++) frm.push_back(8'(i + salt));
        c = crc32(frm, 1040);
        frm.push_back(c[7:0]); frm.push_back(c[15:8]); frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    endtask

    task automatic drive(input logic [7:0] b, input logic dv, input logic er);
        rxd = b; rxdv = dv; rxer = er;
        @(posedge clk125);
        #1;
    endtask

    // Sends preamble+SFD+frm; err_at marks a byte sent with rxer; cut>=0 resets after that many bytes.
    task automatic send(input int ipg, input int err_at, input int cut);
        int len, t0;
        bit hdr_ok, good;
        len = (cut >= 0) ? cut : frm.size();
        hdr_ok = (len >= 14);
        for (int k = 0; k < 6; k++) if (len > k && frm[k] != mac_b[k]) hdr_ok = 0;
        if (len >= 14 && (frm[12] != 8'h19 || frm[13] != 8'h19)) hdr_ok = 0;
        repeat (7) drive(8'h55, 1, 0);
        drive(8'hD5, 1, 0);
        t0 = cyc + 1;
        for (int p = 0; p < len; p++) begin
            if (hdr_ok && p >= 16 && p < 1040) begin
                exp_wr_off[t0 + p] = p - 16;
                exp_wr_dat[t0 + p] = frm[p];
            end
            drive(frm[p], 1, (p == err_at) ? 1'b1 : 1'b0);
        end
        if (cut >= 0) begin
            rst = 1;
            drive(8'h00, 0, 0);
            drive(8'h00, 0, 0);
            rst = 0;
        end else if (hdr_ok) begin
            good = (len == 1044) && !(err_at >= 0 && err_at < len) &&
                   (crc32(frm, 1040) == {frm[1043], frm[1042], frm[1041], frm[1040]});
            if (good) exp_ok_seq[t0 + len] = {frm[15], frm[14]};
            else      exp_bad[t0 + len]    = 1;
        end
        repeat (ipg) drive(8'h00, 0, 0);
    endtask

    initial begin
        byte unsigned tq[$];
        int w0;
        repeat (3) @(posedge clk125);
        #1;
        rst = 0;
        tq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("crc_check_value", crc32(tq, 9), 32'hCBF4_3926);
        repeat (20) drive(8'h00, 0, 0);
        chk("idle_no_writes", n_wr, 0);

        // Good frame, bank 0.
        w0 = n_wr;
        build(16'h0001, 8'h08, 16'h1919, 0);
        send(4, -1, -1);
        chk("f1_writes", n_wr - w0, 1024);
        chk("f1_good_cnt", good_cnt, 16'd1);
        chk("f1_seq", seq, 16'h0001);
        chk("f1_rd_bank", rd_bank, 1'b0);
        // Second good frame lands in bank 1.
        build(16'h0002, 8'h08, 16'h1919, 3);
        send(4, -1, -1);
        chk("f2_rd_bank", rd_bank, 1'b1);
        chk("f2_good_cnt", good_cnt, 16'd2);
        // One payload bit flipped: bad, bank kept for retransmit.
        build(16'h0003, 8'h08, 16'h1919, 0);
        frm[116] = frm[116] ^ 8'h08;
        send(4, -1, -1);
        chk("crc_bad_cnt", bad_cnt, 16'd1);
        chk("crc_bad_rd_bank", rd_bank, 1'b1);
        build(16'h0003, 8'h08, 16'h1919, 0);
        send(4, -1, -1);
        chk("retx_rd_bank", rd_bank, 1'b0);
        chk("retx_seq", seq, 16'h0003);
        // Filter misses: silent.
        w0 = n_wr;
        build(16'h0004, 8'h09, 16'h1919, 0);
        send(4, -1, -1);
        build(16'h0004, 8'h08, 16'h0800, 0);
        send(4, -1, -1);
        chk("filter_no_writes", n_wr - w0, 0);
        chk("filter_counts", {good_cnt, bad_cnt}, {16'd3, 16'd1});
        // Runt, long, rxer mid-payload.
        build(16'h0010, 8'h08, 16'h1919, 7);
        while (frm.size() > 516) void'(frm.pop_back());
        send(4, -1, -1);
        build(16'h0011, 8'h08, 16'h1919, 7);
        frm.push_back(8'hAA);
        send(4, -1, -1);
        build(16'h0012, 8'h08, 16'h1919, 7);
        send(4, 400, -1);
        chk("faults_bad_cnt", bad_cnt, 16'd4);
        chk("faults_good_cnt", good_cnt, 16'd3);

        // Fresh start, back-to-back frames with 1-cycle gap.
        rst = 1;
        repeat (2) drive(8'h00, 0, 0);
        rst = 0;
        build(16'h0005, 8'h08, 16'h1919, 11);
        send(1, -1, -1);
        build(16'h0006, 8'h08, 16'h1919, 12);
        send(2, -1, -1);
        chk("b2b_good_cnt", good_cnt, 16'd2);
        chk("b2b_rd_bank", rd_bank, 1'b1);
        chk("b2b_seq", seq, 16'h0006);
        // Move write bank to 1, then reset mid-payload; next good frame must use bank 0.
        build(16'h0007, 8'h08, 16'h1919, 0);
        send(3, -1, -1);
        build(16'h0008, 8'h08, 16'h1919, 0);
        send(3, -1, 316);
        build(16'h0009, 8'h08, 16'h1919, 5);
        send(3, -1, -1);
        chk("post_rst_rd_bank", rd_bank, 1'b0);
        chk("post_rst_good_cnt", good_cnt, 16'd1);
        chk("post_rst_seq", seq, 16'h0009);

        repeat (5) drive(8'h00, 0, 0);
        chk("pending_expectations",
            exp_wr_off.size() + exp_ok_seq.size() + exp_bad.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
